fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the next-generation core. It replaces the single-cycle PC register and +4 adder path.
- Owns the PC.
- Issues pipelined requests to instruction memory.
- Buffers returned instructions with their PCs in a prefetch queue.
- Hands them to decode over a valid/ready handshake.
- Accepts redirects (branch/jump) from execute, flushing the queue and discarding stale in-flight responses.

---
 rtl/cpu_pkg.sv | 10 +
 rtl/sync_fifo.sv | 43 ++++
 rtl/fetch_queue.sv | 72 +++++++
 tb/tb_fetch_queue.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared core widths, PC step and the fetch entry handed to decode
package cpu_pkg;
  localparam int DEFAULT_XLEN = 32;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;
  typedef struct packed {
    logic [DEFAULT_XLEN-1:0] pc;
    logic [INSTR_W-1:0]      instr;
  } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two synchronous FIFO with flush and occupancy count
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic do_push, do_pop;
  assign full_o = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  assign data_o = mem_q[rd_q];
  assign count_o = cnt_q;
  // storage needs no reset; only pointers and count define contents
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= data_i;
  // pointer and count bookkeeping; flush empties the queue in one cycle
  always_ff @(posedge clk)
    if (reset || clr_i) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: PC owner, pipelined imem requester and prefetch queue feeding decode
module fetch_queue import cpu_pkg::*; #(
  parameter int             XLEN     = DEFAULT_XLEN,
  parameter int             DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int             MAX_OUT  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req_o,
  output logic [XLEN-1:0]            imem_addr_o,
  input  logic                       imem_gnt_i,
  input  logic                       imem_rvalid_i,
  input  logic [INSTR_W-1:0]         imem_rdata_i,
  input  logic                       redirect_i,
  input  logic [XLEN-1:0]            redirect_pc_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [INSTR_W-1:0]         instr_o,
  output logic [XLEN-1:0]            pc_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int OW = $clog2(MAX_OUT+1);
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, redir_pc;
  logic [OW-1:0] out_q, out_d;
  logic [CW-1:0] disc_q, disc_d, occ;
  logic [XLEN+INSTR_W-1:0] head;
  logic issue, push, pop, full, empty, unused;
  assign unused = ^redirect_pc_i[1:0];
  assign redir_pc = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign imem_req_o = !reset && !redirect_i && int'(out_q) < MAX_OUT && int'(occ) + int'(out_q) < DEPTH;
  assign imem_addr_o = fetch_pc_q;
  assign issue = imem_req_o && imem_gnt_i;
  assign push = imem_rvalid_i && disc_q == '0 && !redirect_i;
  assign valid_o = !empty && !redirect_i;
  assign pop = valid_o && ready_i;
  assign {pc_o, instr_o} = head;
  assign occupancy_o = occ;
  sync_fifo #(.WIDTH(XLEN+INSTR_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .clr_i(redirect_i), .push_i(push), .pop_i(pop),
    .data_i({resp_pc_q, imem_rdata_i}), .data_o(head), .full_o(full), .empty_o(empty), .count_o(occ)
  );
  // next PCs, in-flight count and stale-response discard count
  always_comb begin
    fetch_pc_d = redirect_i ? redir_pc : issue ? fetch_pc_q + XLEN'(PC_STEP) : fetch_pc_q;
    resp_pc_d = redirect_i ? redir_pc : push ? resp_pc_q + XLEN'(PC_STEP) : resp_pc_q;
    out_d = out_q + OW'(issue) - OW'(imem_rvalid_i);
    disc_d = redirect_i ? CW'(out_q) - CW'(imem_rvalid_i) :
             (imem_rvalid_i && disc_q != '0) ? disc_q - CW'(1) : disc_q;
  end
  // state registers
  always_ff @(posedge clk)
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q <= RESET_PC;
      out_q <= '0;
      disc_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q <= resp_pc_d;
      out_q <= out_d;
      disc_q <= disc_d;
    end
  // credit scheme must never overfill the queue or mis-count requests
  always @(posedge clk)
    if (!reset) begin
      assert (!(push && full));
      assert (!(imem_rvalid_i && out_q == '0));
      assert (!(issue && int'(out_q) >= MAX_OUT));
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenario checks for fetch_queue
module tb_fetch_queue;
  logic clk = 0, reset = 1;
  logic imem_req_o, imem_gnt_i = 1, imem_rvalid_i = 0;
  logic [31:0] imem_addr_o, imem_rdata_i = '0;
  logic redirect_i = 0, valid_o, ready_i = 0;
  logic [31:0] redirect_pc_i = '0, instr_o, pc_o;
  logic [2:0] occupancy_o;
  int checks = 0, failures = 0;
  logic [31:0] pend[$];
  logic hold = 0;
  fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0), .MAX_OUT(2)) dut (
    .clk(clk), .reset(reset), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .valid_o(valid_o), .ready_i(ready_i),
    .instr_o(instr_o), .pc_o(pc_o), .occupancy_o(occupancy_o)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mw(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction
  task automatic settle();
    imem_rvalid_i = !hold && pend.size() > 0;
    imem_rdata_i = pend.size() > 0 ? mw(pend[0]) : 32'h0;
    #1;
  endtask
  task automatic tick();
    logic fire, rv, rst;
    logic [31:0] fa;
    settle();
    fire = imem_req_o && imem_gnt_i;
    fa = imem_addr_o;
    rv = imem_rvalid_i;
    rst = reset;
    @(posedge clk);
    #1;
    if (rst) pend.delete();
    else begin
      if (rv) void'(pend.pop_front());
      if (fire) pend.push_back(fa);
    end
    settle();
  endtask
  task automatic do_reset();
    reset = 1; redirect_i = 0; hold = 0; imem_gnt_i = 1; ready_i = 0;
    tick(); tick();
    reset = 0;
    settle();
  endtask
  task automatic test_reset();
    reset = 1; ready_i = 1; imem_gnt_i = 1;
    tick(); tick();
    if (imem_req_o !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", imem_req_o); end checks++;
    if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", valid_o); end checks++;
    if (occupancy_o !== 3'd0) begin failures++; $display("FAIL reset_occ: got %0d want 0", occupancy_o); end checks++;
    reset = 0;
    settle();
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin failures++; $display("FAIL reset_first_req: got req=%b addr=%h want 1/00000000", imem_req_o, imem_addr_o); end checks++;
  endtask
  task automatic test_basic();
    do_reset();
    ready_i = 1;
    settle();
    if (valid_o !== 1'b0 || imem_addr_o !== 32'h0) begin failures++; $display("FAIL basic_c0: got valid=%b addr=%h want 0/00000000", valid_o, imem_addr_o); end checks++;
    tick();
    if (valid_o !== 1'b0 || imem_addr_o !== 32'h4) begin failures++; $display("FAIL basic_c1: got valid=%b addr=%h want 0/00000004", valid_o, imem_addr_o); end checks++;
    tick();
    for (int i = 0; i < 5; i++) begin
      if (valid_o !== 1'b1 || pc_o !== 32'(i*4) || instr_o !== mw(32'(i*4))) begin
        failures++; $display("FAIL basic_stream %0d: got valid=%b pc=%h instr=%h want 1/%h/%h", i, valid_o, pc_o, instr_o, 32'(i*4), mw(32'(i*4)));
      end
      checks++;
      tick();
    end
  endtask
  task automatic test_backpressure();
    int occ_exp[6] = '{0, 0, 1, 2, 3, 4};
    int req_exp[6] = '{1, 1, 1, 1, 0, 0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (occupancy_o !== 3'(occ_exp[i]) || imem_req_o !== 1'(req_exp[i])) begin
        failures++; $display("FAIL bp_fill c%0d: got occ=%0d req=%b want %0d/%0d", i, occupancy_o, imem_req_o, occ_exp[i], req_exp[i]);
      end
      checks++;
      tick();
    end
    repeat (4) tick();
    if (occupancy_o !== 3'd4 || imem_req_o !== 1'b0 || valid_o !== 1'b1) begin failures++; $display("FAIL bp_saturate: got occ=%0d req=%b valid=%b want 4/0/1", occupancy_o, imem_req_o, valid_o); end checks++;
    ready_i = 1;
    settle();
    for (int i = 0; i < 4; i++) begin
      if (valid_o !== 1'b1 || pc_o !== 32'(i*4) || instr_o !== mw(32'(i*4))) begin
        failures++; $display("FAIL bp_drain %0d: got valid=%b pc=%h instr=%h want 1/%h/%h", i, valid_o, pc_o, instr_o, 32'(i*4), mw(32'(i*4)));
      end
      checks++;
      if (i == 1) begin
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h10) begin failures++; $display("FAIL bp_resume: got req=%b addr=%h want 1/00000010", imem_req_o, imem_addr_o); end
        checks++;
      end
      tick();
    end
  endtask
  task automatic test_redirect_discard();
    do_reset();
    ready_i = 1; hold = 1;
    tick(); tick();
    redirect_i = 1; redirect_pc_i = 32'h100;
    settle();
    if (imem_req_o !== 1'b0 || valid_o !== 1'b0) begin failures++; $display("FAIL rd_pulse: got req=%b valid=%b want 0/0", imem_req_o, valid_o); end checks++;
    tick();
    redirect_i = 0; hold = 0;
    settle();
    if (occupancy_o !== 3'd0 || valid_o !== 1'b0) begin failures++; $display("FAIL rd_empty: got occ=%0d valid=%b want 0/0", occupancy_o, valid_o); end checks++;
    tick();
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin failures++; $display("FAIL rd_newreq: got req=%b addr=%h want 1/00000100", imem_req_o, imem_addr_o); end checks++;
    tick();
    if (valid_o !== 1'b0) begin failures++; $display("FAIL rd_dropped: got valid=%b want 0", valid_o); end checks++;
    tick();
    for (int i = 0; i < 2; i++) begin
      if (valid_o !== 1'b1 || pc_o !== 32'h100 + 32'(i*4) || instr_o !== mw(32'h100 + 32'(i*4))) begin
        failures++; $display("FAIL rd_deliver %0d: got valid=%b pc=%h instr=%h want 1/%h/%h", i, valid_o, pc_o, instr_o, 32'h100 + 32'(i*4), mw(32'h100 + 32'(i*4)));
      end
      checks++;
      tick();
    end
  endtask
  task automatic redirect_from_steady(input logic [31:0] target);
    do_reset();
    ready_i = 1;
    tick(); tick(); tick();
    redirect_i = 1; redirect_pc_i = target;
    settle();
  endtask
  task automatic test_redirect_rvalid();
    redirect_from_steady(32'h203);
    if (imem_rvalid_i !== 1'b1 || valid_o !== 1'b0 || imem_req_o !== 1'b0) begin failures++; $display("FAIL rv_pulse: got rvalid=%b valid=%b req=%b want 1/0/0", imem_rvalid_i, valid_o, imem_req_o); end checks++;
    tick();
    redirect_i = 0;
    settle();
    if (occupancy_o !== 3'd0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin failures++; $display("FAIL rv_after: got occ=%0d req=%b addr=%h want 0/1/00000200", occupancy_o, imem_req_o, imem_addr_o); end checks++;
    tick(); tick();
    if (valid_o !== 1'b1 || pc_o !== 32'h200 || instr_o !== mw(32'h200)) begin failures++; $display("FAIL rv_deliver: got valid=%b pc=%h instr=%h want 1/00000200/%h", valid_o, pc_o, instr_o, mw(32'h200)); end checks++;
  endtask
  task automatic test_wrap();
    logic [31:0] e;
    redirect_from_steady(32'hFFFF_FFF8);
    tick();
    redirect_i = 0;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      e = 32'hFFFF_FFF8 + 32'(i*4);
      if (valid_o !== 1'b1 || pc_o !== e || instr_o !== mw(e)) begin
        failures++; $display("FAIL wrap %0d: got valid=%b pc=%h instr=%h want 1/%h/%h", i, valid_o, pc_o, instr_o, e, mw(e));
      end
      checks++;
      tick();
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    tick(); tick(); tick();
    hold = 1;
    tick();
    if (occupancy_o !== 3'd2 || imem_req_o !== 1'b0) begin failures++; $display("FAIL rm_pre: got occ=%0d req=%b want 2/0", occupancy_o, imem_req_o); end checks++;
    reset = 1;
    tick();
    if (valid_o !== 1'b0 || occupancy_o !== 3'd0 || imem_req_o !== 1'b0) begin failures++; $display("FAIL rm_cleared: got valid=%b occ=%0d req=%b want 0/0/0", valid_o, occupancy_o, imem_req_o); end checks++;
    reset = 0; hold = 0; ready_i = 1;
    settle();
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin failures++; $display("FAIL rm_restart: got req=%b addr=%h want 1/00000000", imem_req_o, imem_addr_o); end checks++;
    tick(); tick();
    if (valid_o !== 1'b1 || pc_o !== 32'h0 || instr_o !== mw(32'h0)) begin failures++; $display("FAIL rm_deliver: got valid=%b pc=%h instr=%h want 1/00000000/%h", valid_o, pc_o, instr_o, mw(32'h0)); end checks++;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect_discard();
    test_redirect_rvalid();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
